// File: rtl/conv_output_serializer.sv
// conv_output_serializer
//   Transmitter side of the layer-to-layer stream. Buffers up to two
//   N_CHANNELS-wide result vectors from the upstream convolutional layer and
//   serializes them channel-0-first into a single-word stream for the next
//   layer. A one-cycle start pulse precedes every frame of FRAME_ROWS vectors.
//
// Ports
//   clk_i      clock, all logic on the rising edge
//   reset_n_i  synchronous, active-low reset
//   valid_i    upstream vector valid
//   ready_o    buffer can accept a vector (independent of valid_i)
//   data_i     packed vector, word c at [c*WORD_SIZE +: WORD_SIZE]
//   valid_o    data_o holds a valid word
//   yumi_i     downstream consumes data_o this cycle
//   data_o     current serialized word (0 while valid_o=0)
//   start_o    one-cycle frame-start pulse
//   last_o     data_o is the final word of the current frame
module conv_output_serializer #(
  parameter int unsigned N_CHANNELS = 2,
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned FRAME_ROWS = 64
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [N_CHANNELS*WORD_SIZE-1:0]  data_i,
  output logic                             valid_o,
  input  logic                             yumi_i,
  output logic [WORD_SIZE-1:0]             data_o,
  output logic                             start_o,
  output logic                             last_o
);

  localparam int unsigned CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int unsigned ROW_W = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CHANNELS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_ROWS - 1);

  typedef enum logic [1:0] {
    eIDLE,
    eSTART,
    eSTREAM
  } state_e;

  state_e state_q;

  // Two-entry vector FIFO
  logic [N_CHANNELS-1:0][WORD_SIZE-1:0] buf_q [2];
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             wr_ptr_q;
  logic             rd_ptr_q;

  // Serialization position
  logic [CH_W-1:0]  ch_q;
  logic [ROW_W-1:0] row_q;

  logic handshake_in;
  logic handshake_out;
  logic ch_last;
  logic row_last;
  logic pop;

  assign ready_o       = reset_n_i & (count_q != 2'd2);
  assign handshake_in  = valid_i & ready_o;
  assign handshake_out = valid_o & yumi_i;
  assign ch_last       = (ch_q == CH_LAST);
  assign row_last      = (row_q == ROW_LAST);
  assign pop           = handshake_out & ch_last;

  assign data_o = valid_o ? buf_q[rd_ptr_q][ch_q] : '0;
  assign last_o = valid_o & ch_last & row_last;

  always_comb begin
    count_d = count_q;
    case ({handshake_in, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Vector storage carries no reset; entries are only read once counted.
  always_ff @(posedge clk_i) begin
    if (handshake_in) begin
      buf_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ch_q     <= '0;
      row_q    <= '0;
    end else begin
      count_q <= count_d;
      if (handshake_in) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (handshake_out) begin
        if (ch_last) begin
          ch_q     <= '0;
          rd_ptr_q <= ~rd_ptr_q;
          row_q    <= row_last ? '0 : row_q + 1'b1;
        end else begin
          ch_q <= ch_q + 1'b1;
        end
      end
    end
  end

  // valid_o is registered from the next-cycle view: streaming state and a
  // non-empty buffer after this edge's push/pop (count_d).
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= eIDLE;
      valid_o <= 1'b0;
      start_o <= 1'b0;
    end else begin
      start_o <= 1'b0;
      case (state_q)
        eIDLE: begin
          valid_o <= 1'b0;
          if ((count_q != 2'd0) || handshake_in) begin
            state_q <= eSTART;
            start_o <= 1'b1;
          end
        end
        eSTART: begin
          state_q <= eSTREAM;
          valid_o <= (count_d != 2'd0);
        end
        eSTREAM: begin
          if (handshake_out && last_o) begin
            state_q <= eIDLE;
            valid_o <= 1'b0;
          end else begin
            valid_o <= (count_d != 2'd0);
          end
        end
        default: begin
          state_q <= eIDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_output_serializer.sv
module tb_conv_output_serializer;

  localparam int unsigned NCH  = 2;
  localparam int unsigned WS   = 16;
  localparam int unsigned ROWS = 4;
  localparam int unsigned WPF  = NCH * ROWS;

  logic              clk_i     = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              valid_i   = 1'b0;
  logic              ready_o;
  logic [NCH*WS-1:0] data_i    = '0;
  logic              valid_o;
  logic              yumi_i    = 1'b0;
  logic [WS-1:0]     data_o;
  logic              start_o;
  logic              last_o;

  conv_output_serializer #(
    .N_CHANNELS(NCH),
    .WORD_SIZE (WS),
    .FRAME_ROWS(ROWS)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .yumi_i   (yumi_i),
    .data_o   (data_o),
    .start_o  (start_o),
    .last_o   (last_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: queue of words still owed downstream, vectors held,
  // words delivered since reset, and frame open / start-pending flags.
  logic [WS-1:0]     m_words[$];
  int unsigned       m_vecs      = 0;
  int unsigned       words_out   = 0;
  bit                m_open      = 1'b0;
  bit                m_start_due = 1'b0;

  // Upstream source
  logic [NCH*WS-1:0] in_q[$];
  bit                in_en = 1'b1;

  logic          s_ready, s_valid, s_start, s_last;
  logic [WS-1:0] s_data;
  logic          e_ready, e_valid, e_start, e_last;
  logic [WS-1:0] e_data;

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic drive_inputs();
    valid_i = in_en && (in_q.size() != 0);
    data_i  = (in_q.size() != 0) ? in_q[0] : '0;
  endtask

  task automatic sample();
    @(negedge clk_i);
    s_ready = ready_o;
    s_valid = valid_o;
    s_start = start_o;
    s_last  = last_o;
    s_data  = data_o;
    e_ready = reset_n_i && (m_vecs < 2);
    e_valid = m_open && (m_words.size() != 0);
    e_start = m_start_due;
    e_data  = e_valid ? m_words[0] : '0;
    e_last  = e_valid && ((words_out % WPF) == WPF - 1);
  endtask

  task automatic advance();
    bit acc, pop, had;
    @(posedge clk_i);
    acc = reset_n_i && valid_i && s_ready;
    pop = reset_n_i && s_valid && yumi_i;
    if (!reset_n_i) begin
      m_words.delete();
      m_vecs      = 0;
      words_out   = 0;
      m_open      = 1'b0;
      m_start_due = 1'b0;
    end else begin
      had = (m_words.size() != 0);
      if (pop) begin
        void'(m_words.pop_front());
        words_out++;
        if (words_out % NCH == 0) m_vecs--;
      end
      if (acc) begin
        for (int c = 0; c < NCH; c++) m_words.push_back(data_i[c*WS +: WS]);
        m_vecs++;
        void'(in_q.pop_front());
      end
      if (m_start_due) begin
        m_start_due = 1'b0;
        m_open      = 1'b1;
      end else if (!m_open && (had || acc)) begin
        m_start_due = 1'b1;
      end
      if (pop && (words_out % WPF == 0)) m_open = 1'b0;
    end
    #1;
    drive_inputs();
  endtask

  task automatic apply_reset();
    in_q.delete();
    in_en     = 1'b1;
    yumi_i    = 1'b0;
    reset_n_i = 1'b0;
    drive_inputs();
    sample();
    advance();
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    yumi_i    = 1'b1;
    in_en     = 1'b1;
    in_q.delete();
    in_q.push_back(32'h0002_0001);
    drive_inputs();
    for (int i = 0; i < 2; i++) begin
      sample();
      total++;
      if (s_ready !== 1'b0) $display("FAIL reset_ready_forced cyc %0d: ready_o=%b want 0", i, s_ready);
      else passed++;
      advance();
    end
    reset_n_i = 1'b1;
    yumi_i    = 1'b0;
    in_q.delete();
    drive_inputs();
    sample();
    total++;
    if ({s_ready, s_valid, s_start, s_last, s_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_state: r%b v%b s%b l%b d=%h want r1 v0 s0 l0 d=0000",
               s_ready, s_valid, s_start, s_last, s_data);
    else passed++;
    advance();
  endtask

  task automatic test_first_vector();
    apply_reset();
    yumi_i = 1'b1;
    in_q.push_back({16'h0002, 16'h0001});
    drive_inputs();
    sample();
    total++;
    if ({s_ready, s_valid, s_start} !== 3'b100)
      $display("FAIL first_pre_push: r%b v%b s%b want r1 v0 s0", s_ready, s_valid, s_start);
    else passed++;
    advance();
    sample();
    total++;
    if ({s_start, s_valid} !== 2'b10)
      $display("FAIL first_start_pulse: start=%b valid=%b want start=1 valid=0", s_start, s_valid);
    else passed++;
    advance();
    sample();
    total++;
    if ({s_valid, s_last, s_data} !== {1'b1, 1'b0, 16'h0001})
      $display("FAIL first_word0: v%b l%b d=%h want v1 l0 d=0001", s_valid, s_last, s_data);
    else passed++;
    advance();
    sample();
    total++;
    if ({s_valid, s_last, s_data} !== {1'b1, 1'b0, 16'h0002})
      $display("FAIL first_word1: v%b l%b d=%h want v1 l0 d=0002", s_valid, s_last, s_data);
    else passed++;
    advance();
    sample();
    total++;
    if ({s_valid, s_start, s_data} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL first_drained: v%b s%b d=%h want v0 s0 d=0000", s_valid, s_start, s_data);
    else passed++;
    advance();
  endtask

  task automatic test_back_to_back();
    int unsigned   lasts = 0, first_cyc = 0, last_cyc = 0;
    bit            seen_first = 1'b0, saw_full = 1'b0;
    logic [WS-1:0] last_word = '0;
    apply_reset();
    yumi_i = 1'b1;
    for (int v = 0; v < 4; v++) in_q.push_back({16'(17 + 2*v), 16'(16 + 2*v)});
    drive_inputs();
    for (int cyc = 0; cyc < 40 && words_out < 8; cyc++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL b2b_cycle %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      if (!s_ready) saw_full = 1'b1;
      if (s_valid && !seen_first) begin
        seen_first = 1'b1;
        first_cyc  = cyc;
      end
      if (s_last) begin
        lasts++;
        last_word = s_data;
        last_cyc  = cyc;
      end
      advance();
    end
    total++;
    if (words_out != 8) $display("FAIL b2b_done: words=%0d want 8", words_out);
    else passed++;
    total++;
    if (lasts != 1 || last_word !== 16'h0017)
      $display("FAIL b2b_last: last count=%0d word=%h want 1 on 0017", lasts, last_word);
    else passed++;
    total++;
    if (last_cyc - first_cyc != 7)
      $display("FAIL b2b_contiguous: span=%0d cycles want 7", last_cyc - first_cyc);
    else passed++;
    total++;
    if (!saw_full) $display("FAIL b2b_ready_low: ready_o never 0 want 0 while full");
    else passed++;
    for (int i = 0; i < 3; i++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_ready} !== 3'b001)
        $display("FAIL b2b_idle %0d: v%b s%b r%b want v0 s0 r1", i, s_valid, s_start, s_ready);
      else passed++;
      advance();
    end
  endtask

  task automatic test_stall();
    int unsigned stall_cnt = 0;
    bit          stalled = 1'b0;
    apply_reset();
    yumi_i = 1'b1;
    for (int v = 0; v < 4; v++) in_q.push_back({16'(17 + 2*v), 16'(16 + 2*v)});
    drive_inputs();
    for (int cyc = 0; cyc < 50 && words_out < 8; cyc++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL stall_cycle %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      if (stall_cnt != 0) begin
        total++;
        if (s_valid !== 1'b1 || s_data !== 16'h0013)
          $display("FAIL stall_hold %0d: v%b d=%h want v1 d=0013", stall_cnt, s_valid, s_data);
        else passed++;
      end
      advance();
      if (stall_cnt != 0) stall_cnt--;
      if (!stalled && words_out == 3) begin
        stalled   = 1'b1;
        stall_cnt = 5;
      end
      yumi_i = (stall_cnt == 0);
    end
    total++;
    if (words_out != 8 || m_words.size() != 0)
      $display("FAIL stall_done: words=%0d pending=%0d want 8/0", words_out, m_words.size());
    else passed++;
  endtask

  task automatic test_frame_boundary();
    bit            after_last = 1'b0, done_gap = 1'b0;
    int unsigned   gap = 0, starts_gap = 0, starts_all = 0;
    logic [WS-1:0] next_word = '0;
    apply_reset();
    yumi_i = 1'b1;
    for (int v = 0; v < 4; v++) in_q.push_back({16'(17 + 2*v), 16'(16 + 2*v)});
    in_q.push_back({16'h0021, 16'h0020});
    drive_inputs();
    for (int cyc = 0; cyc < 60 && words_out < 10; cyc++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL frame_cycle %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      if (s_start) starts_all++;
      if (after_last && !done_gap) begin
        if (s_valid) begin
          done_gap  = 1'b1;
          next_word = s_data;
        end else begin
          gap++;
          if (s_start) starts_gap++;
        end
      end
      if (s_last) after_last = 1'b1;
      advance();
    end
    total++;
    if (words_out != 10) $display("FAIL frame_done: words=%0d want 10", words_out);
    else passed++;
    total++;
    if (gap != 2 || starts_gap != 1)
      $display("FAIL frame_gap: gap=%0d starts=%0d want 2/1", gap, starts_gap);
    else passed++;
    total++;
    if (next_word !== 16'h0020) $display("FAIL frame_next_word: d=%h want 0020", next_word);
    else passed++;
    total++;
    if (starts_all != 2) $display("FAIL frame_start_count: %0d want 2", starts_all);
    else passed++;
  endtask

  task automatic test_yumi_idle();
    bit            seen = 1'b0;
    logic [WS-1:0] first = '0;
    apply_reset();
    yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_ready} !== 3'b001)
        $display("FAIL yumi_idle_state %0d: v%b s%b r%b want v0 s0 r1", i, s_valid, s_start, s_ready);
      else passed++;
      advance();
    end
    in_q.push_back({16'h0032, 16'h0031});
    drive_inputs();
    for (int cyc = 0; cyc < 10 && words_out < 2; cyc++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL yumi_cycle %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_data} !== {1'b0, 1'b0, 16'h0000})
        $display("FAIL yumi_empty_stream %0d: v%b s%b d=%h want v0 s0 d=0000", i, s_valid, s_start, s_data);
      else passed++;
      advance();
    end
    in_q.push_back({16'h0034, 16'h0033});
    drive_inputs();
    for (int cyc = 0; cyc < 10 && words_out < 4; cyc++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL yumi_resume %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      if (s_valid && !seen) begin
        seen  = 1'b1;
        first = s_data;
      end
      advance();
    end
    total++;
    if (!seen || first !== 16'h0033 || words_out != 4)
      $display("FAIL yumi_next_word: seen=%b d=%h words=%0d want 1/0033/4", seen, first, words_out);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    bit            seen = 1'b0, started = 1'b0;
    logic [WS-1:0] first = '0;
    apply_reset();
    yumi_i = 1'b1;
    in_q.push_back({16'h0041, 16'h0040});
    in_q.push_back({16'h0043, 16'h0042});
    drive_inputs();
    for (int cyc = 0; cyc < 20 && words_out < 3; cyc++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL midrst_cycle %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      advance();
    end
    total++;
    if (words_out != 3) $display("FAIL midrst_progress: words=%0d want 3", words_out);
    else passed++;
    reset_n_i = 1'b0;
    sample();
    total++;
    if (s_ready !== 1'b0) $display("FAIL midrst_ready_forced: ready_o=%b want 0", s_ready);
    else passed++;
    advance();
    reset_n_i = 1'b1;
    in_q.delete();
    drive_inputs();
    sample();
    total++;
    if ({s_valid, s_ready, s_start, s_data} !== {1'b0, 1'b1, 1'b0, 16'h0000})
      $display("FAIL midrst_after: v%b r%b s%b d=%h want v0 r1 s0 d=0000", s_valid, s_ready, s_start, s_data);
    else passed++;
    advance();
    in_q.push_back({16'h0052, 16'h0051});
    drive_inputs();
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL midrst_restart %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      if (s_start) started = 1'b1;
      if (s_valid) begin
        seen  = 1'b1;
        first = s_data;
      end
      advance();
    end
    total++;
    if (!seen || !started || first !== 16'h0051)
      $display("FAIL midrst_fresh_frame: start=%b seen=%b d=%h want 1/1/0051", started, seen, first);
    else passed++;
  endtask

  task automatic test_random();
    logic [NCH*WS-1:0] rv;
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (in_q.size() < 3 && $urandom_range(1, 0) == 1) begin
        rv = $urandom();
        in_q.push_back(rv);
      end
      in_en  = ($urandom_range(9, 0) < 7);
      yumi_i = ($urandom_range(9, 0) < 6);
      drive_inputs();
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL rand_cycle %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      advance();
    end
    in_en  = 1'b1;
    yumi_i = 1'b1;
    drive_inputs();
    for (int cyc = 0; cyc < 200 && (in_q.size() != 0 || m_words.size() != 0); cyc++) begin
      sample();
      total++;
      if ({s_valid, s_start, s_last, s_ready, s_data} !== {e_valid, e_start, e_last, e_ready, e_data})
        $display("FAIL rand_drain %0d: got v%b s%b l%b r%b d=%h want v%b s%b l%b r%b d=%h", cyc,
                 s_valid, s_start, s_last, s_ready, s_data, e_valid, e_start, e_last, e_ready, e_data);
      else passed++;
      advance();
    end
    total++;
    if (in_q.size() != 0 || m_words.size() != 0)
      $display("FAIL rand_drained: source=%0d words pending=%0d want 0/0", in_q.size(), m_words.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_first_vector();
    test_back_to_back();
    test_stall();
    test_frame_boundary();
    test_yumi_idle();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
